// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-port (instruction fetch / data load-store) arbiter in front
//            of a single-ported word-wide RAM with combinational read data.
//            Round-robin grant, alignment/range checking, byte-enable stores
//            via read-modify-write, and one-cycle done/err pulses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_LAST    highest valid byte address of the attached RAM
// Ports
//   clk         system clock, all state changes on its rising edge
//   reset       synchronous active-high reset
//   i_req       instruction fetch request (held until i_done/i_err)
//   i_addr      instruction byte address
//   i_rdata     fetched word, held until the next instruction completion
//   i_done      one-cycle completion pulse for the instruction port
//   i_err       one-cycle error pulse for the instruction port
//   d_req       data request (held until d_done/d_err)
//   d_we        1 = store, 0 = load
//   d_addr      data byte address
//   d_wdata     store data
//   d_be        store byte enables, bit k selects byte k
//   d_rdata     loaded word, held until the next data load completion
//   d_done      one-cycle completion pulse for the data port
//   d_err       one-cycle error pulse for the data port
//   mem_addr    word-aligned RAM address (registered)
//   mem_wdata   RAM write data (registered)
//   mem_read    RAM read strobe (registered)
//   mem_write   RAM write strobe (registered)
//   mem_rdata   combinational read data from the RAM
// ============================================================================
module ram_arbiter #(
  parameter int MEM_LAST = 1000
) (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  // RAM port
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_RD     = 3'd1;
  localparam logic [2:0] c_ST_RMW_RD = 3'd2;
  localparam logic [2:0] c_ST_RMW_WR = 3'd3;
  localparam logic [2:0] c_ST_WR     = 3'd4;
  localparam logic [2:0] c_ST_RESP   = 3'd5;

  // Range limit widened by one bit so addr+3 cannot wrap around.
  localparam logic [32:0] c_MEM_LAST = 33'(MEM_LAST);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;

  // Latched request context (valid from the grant edge onward)
  logic        r_gnt_d;     // 1 = data port owns the current transaction
  logic        r_last_d;    // 1 = data port was granted last
  logic        r_err;       // current transaction failed its address check
  logic [31:0] r_wdata;
  logic [3:0]  r_be;

  // Arbitration / checking
  logic        w_any_req;
  logic        w_sel_d;
  logic        w_sel_we;
  logic [31:0] w_addr;
  logic [32:0] w_addr_end;
  logic        w_chk_err;

  // Next values of the registered outputs
  logic        w_resp_err;
  logic        w_resp_d;
  logic        w_enter_resp;
  logic        w_mem_read_nxt;
  logic        w_mem_write_nxt;
  logic        w_i_done_nxt;
  logic        w_i_err_nxt;
  logic        w_d_done_nxt;
  logic        w_d_err_nxt;

  // Byte-merged write word for partial stores
  logic [31:0] w_merge;

  // --------------------------------------------------------------------------
  // Arbitration and address check (only meaningful while in IDLE)
  // --------------------------------------------------------------------------
  always_comb begin
    w_any_req  = i_req | d_req;
    // Data wins when it is alone, or on a conflict when it was not last.
    w_sel_d    = d_req & (~i_req | ~r_last_d);
    w_sel_we   = w_sel_d & d_we;
    w_addr     = w_sel_d ? d_addr : i_addr;
    w_addr_end = {1'b0, w_addr} + 33'd3;
    w_chk_err  = (w_addr[1:0] != 2'b00) | (w_addr_end > c_MEM_LAST);
  end

  // --------------------------------------------------------------------------
  // Partial-store merge: new byte where enabled, old RAM byte elsewhere
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign w_merge[gi*8 +: 8] = r_be[gi] ? r_wdata[gi*8 +: 8]
                                         : mem_rdata[gi*8 +: 8];
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_any_req) begin
          if (w_chk_err) begin
            w_state_nxt = c_ST_RESP;
          end else if (!w_sel_we) begin
            w_state_nxt = c_ST_RD;
          end else if (d_be == 4'b1111) begin
            w_state_nxt = c_ST_WR;
          end else if (d_be == 4'b0000) begin
            // Store with nothing enabled completes without touching RAM.
            w_state_nxt = c_ST_RESP;
          end else begin
            w_state_nxt = c_ST_RMW_RD;
          end
        end
      end
      c_ST_RD:     w_state_nxt = c_ST_RESP;
      c_ST_RMW_RD: w_state_nxt = c_ST_RMW_WR;
      c_ST_RMW_WR: w_state_nxt = c_ST_RESP;
      c_ST_WR:     w_state_nxt = c_ST_RESP;
      c_ST_RESP:   w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic. Outputs are registered, so this computes the value
  // each output takes in the state being entered.
  // --------------------------------------------------------------------------
  always_comb begin
    // In IDLE the transaction is being granted this cycle, so its owner and
    // error status come straight from arbitration rather than the latches.
    w_resp_err = r_err;
    w_resp_d   = r_gnt_d;
    if (r_state == c_ST_IDLE) begin
      w_resp_err = w_chk_err;
      w_resp_d   = w_sel_d;
    end

    w_enter_resp    = (w_state_nxt == c_ST_RESP);
    w_mem_read_nxt  = (w_state_nxt == c_ST_RD) | (w_state_nxt == c_ST_RMW_RD);
    w_mem_write_nxt = (w_state_nxt == c_ST_WR) | (w_state_nxt == c_ST_RMW_WR);

    w_i_done_nxt = w_enter_resp & ~w_resp_err & ~w_resp_d;
    w_i_err_nxt  = w_enter_resp &  w_resp_err & ~w_resp_d;
    w_d_done_nxt = w_enter_resp & ~w_resp_err &  w_resp_d;
    w_d_err_nxt  = w_enter_resp &  w_resp_err &  w_resp_d;
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt_d   <= 1'b0;
      r_last_d  <= 1'b0;   // instruction counts as last, so data wins first
      r_err     <= 1'b0;
      r_wdata   <= 32'd0;
      r_be      <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      i_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
      i_done    <= 1'b0;
      i_err     <= 1'b0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      mem_read  <= w_mem_read_nxt;
      mem_write <= w_mem_write_nxt;
      i_done    <= w_i_done_nxt;
      i_err     <= w_i_err_nxt;
      d_done    <= w_d_done_nxt;
      d_err     <= w_d_err_nxt;

      // Grant: capture everything needed so later input changes are ignored.
      if ((r_state == c_ST_IDLE) && w_any_req) begin
        r_gnt_d  <= w_sel_d;
        r_last_d <= w_sel_d;
        r_err    <= w_chk_err;
        r_wdata  <= d_wdata;
        r_be     <= d_be;
        mem_addr <= {w_addr[31:2], 2'b00};
        if (w_sel_we) begin
          mem_wdata <= d_wdata;
        end
      end

      // Load data: the RAM read is combinational, capture in the RD cycle.
      if (r_state == c_ST_RD) begin
        if (r_gnt_d) begin
          d_rdata <= mem_rdata;
        end else begin
          i_rdata <= mem_rdata;
        end
      end

      // Old word is available now; present the merged word for RMW_WR.
      if (r_state == c_ST_RMW_RD) begin
        mem_wdata <= w_merge;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter with a behavioural RAM,
//            a response scoreboard, a vector table and corner-case sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  ram_arbiter #(.MEM_LAST(1000)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .d_err     (d_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  // Behavioural RAM: combinational read, write on rising edge.
  logic [31:0] ram [0:255];
  logic        preload;
  assign mem_rdata = ram[mem_addr[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'hA500_0000 | 32'(i);
      ram[64] <= 32'h1122_3344;   // 0x100
      ram[65] <= 32'hAABB_CCDD;   // 0x104
    end else if (mem_write) begin
      ram[mem_addr[9:2]] <= mem_wdata;
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;     // 0 = instruction, 1 = data
    bit          err;
    bit          chk_rd;
    logic [31:0] rdata;
    int          lat;      // -1 = not checked
    int          start;
    int          rd;       // -1 = not checked
    int          wr;
    int          rd_base;
    int          wr_base;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic exp_t mk(input bit port, input bit we, input bit err,
                              input logic [31:0] rdata, input int lat,
                              input int rd, input int wr,
                              input logic [31:0] addr, input logic [31:0] wexp);
    exp_t e;
    e.port    = port;
    e.err     = err;
    e.chk_rd  = !err && !(port && we);
    e.rdata   = rdata;
    e.lat     = lat;
    e.start   = cyc;
    e.rd      = rd;
    e.wr      = wr;
    e.rd_base = rd_cnt;
    e.wr_base = wr_cnt;
    e.waddr   = {addr[31:2], 2'b00};
    e.wdata   = wexp;
    return e;
  endfunction

  function automatic void chk_resp(input bit p);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_resp: port %0d pulsed with nothing outstanding", p);
      return;
    end
    e = sb.pop_front();
    chk("resp_port", 32'(p), 32'(e.port));
    if (p) chk("d_done_err", {30'd0, d_done, d_err}, {30'd0, !e.err, e.err});
    else   chk("i_done_err", {30'd0, i_done, i_err}, {30'd0, !e.err, e.err});
    if (e.lat >= 0) chk("latency", 32'(cyc - e.start), 32'(e.lat));
    if (e.rd >= 0)  chk("read_strobes", 32'(rd_cnt - e.rd_base), 32'(e.rd));
    if (e.wr >= 0)  chk("write_strobes", 32'(wr_cnt - e.wr_base), 32'(e.wr));
    if (e.chk_rd) chk(p ? "d_rdata" : "i_rdata", p ? d_rdata : i_rdata, e.rdata);
  endfunction

  // Monitor: strobe sanity, RAM-side address/data, and response scoreboard.
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
      if (sb.size() > 0) begin
        chk("mem_addr", mem_addr, sb[0].waddr);
        if (mem_write) chk("mem_wdata", mem_wdata, sb[0].wdata);
      end
    end
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (i_done || i_err) chk_resp(1'b0);
    if (d_done || d_err) chk_resp(1'b1);
  end

  task automatic wait_done(input bit port);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = port ? (d_done | d_err) : (i_done | i_err);
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL timeout: port %0d got no done/err within 20 cycles", port);
    end
  endtask

  task automatic run_txn(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input bit err, input logic [31:0] rdata, input int lat,
                         input int rd, input int wr, input logic [31:0] wexp);
    @(posedge clk); #1;
    sb.push_back(mk(port, we, err, rdata, lat, rd, wr, addr, wexp));
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    wait_done(port);
    @(posedge clk); #1;
    if (port) begin
      d_req = 1'b0; d_wdata = 32'hFFFF_FFFF; d_addr = 32'h3;
    end else begin
      i_req = 1'b0; i_addr = 32'h3;
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          err;
    logic [31:0] rdata;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wexp;
  } vec_t;

  vec_t vt [14];

  initial begin
    int wbase;
    // port we addr wdata be err rdata lat rd wr wexp
    vt[0]  = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 1'b0, 32'h1122_3344, 2, 1, 0, 32'h0};
    vt[1]  = '{1'b1, 1'b1, 32'h104, 32'h1122_3344, 4'h5, 1'b0, 32'h0,        3, 1, 1, 32'hAA22_CC44};
    vt[2]  = '{1'b1, 1'b0, 32'h104, 32'h5555_5555, 4'h0, 1'b0, 32'hAA22_CC44, 2, 1, 0, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 32'h102, 32'h0,        4'hF, 1'b1, 32'h0,        1, 0, 0, 32'h0};
    vt[4]  = '{1'b1, 1'b1, 32'h3E6, 32'h1234_5678, 4'hF, 1'b1, 32'h0,        1, 0, 0, 32'h0};
    vt[5]  = '{1'b0, 1'b0, 32'h101, 32'h0,        4'h0, 1'b1, 32'h0,        1, 0, 0, 32'h0};
    vt[6]  = '{1'b1, 1'b1, 32'h108, 32'hCAFE_F00D, 4'h0, 1'b0, 32'h0,        1, 0, 0, 32'h0};
    vt[7]  = '{1'b1, 1'b0, 32'h108, 32'h0,        4'h0, 1'b0, 32'hA500_0042, 2, 1, 0, 32'h0};
    vt[8]  = '{1'b1, 1'b1, 32'h10C, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,        2, 0, 1, 32'hDEAD_BEEF};
    vt[9]  = '{1'b0, 1'b0, 32'h10C, 32'h0,        4'h0, 1'b0, 32'hDEAD_BEEF, 2, 1, 0, 32'h0};
    vt[10] = '{1'b1, 1'b0, 32'h3E4, 32'h0,        4'h0, 1'b0, 32'hA500_00F9, 2, 1, 0, 32'h0};
    vt[11] = '{1'b0, 1'b0, 32'h3E8, 32'h0,        4'h0, 1'b1, 32'h0,        1, 0, 0, 32'h0};
    vt[12] = '{1'b1, 1'b1, 32'h110, 32'h7700_0000, 4'h8, 1'b0, 32'h0,        3, 1, 1, 32'h7700_0044};
    vt[13] = '{1'b0, 1'b0, 32'h110, 32'h0,        4'h0, 1'b0, 32'h7700_0044, 2, 1, 0, 32'h0};

    reset = 1'b1; preload = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; preload = 1'b0;
    @(negedge clk);
    chk("reset_rdata", i_rdata | d_rdata, 32'd0);
    chk("reset_mem", mem_addr | mem_wdata, 32'd0);
    chk("reset_strobes", {26'd0, mem_read, mem_write, i_done, i_err, d_done, d_err}, 32'd0);

    // First conflict after reset goes to data; both held, grants alternate.
    @(posedge clk); #1;
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 32'hAABB_CCDD, -1, -1, -1, 32'h104, 32'h0));
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 32'h1122_3344, -1, -1, -1, 32'h100, 32'h0));
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 32'h1122_3344, -1, -1, -1, 32'h100, 32'h0));
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 32'hA500_0042, -1, -1, -1, 32'h108, 32'h0));
    fork
      begin
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
        wait_done(1'b1);
        @(posedge clk); #1; d_addr = 32'h100;
        wait_done(1'b1);
        @(posedge clk); #1; d_req = 1'b0;
      end
      begin
        i_req = 1'b1; i_addr = 32'h100;
        wait_done(1'b0);
        @(posedge clk); #1; i_addr = 32'h108;
        wait_done(1'b0);
        @(posedge clk); #1; i_req = 1'b0;
      end
    join
    chk("rr_all_served", 32'(sb.size()), 32'd0);

    for (int k = 0; k < 14; k++) begin
      run_txn(vt[k].port, vt[k].we, vt[k].addr, vt[k].wdata, vt[k].be,
              vt[k].err, vt[k].rdata, vt[k].lat, vt[k].rd, vt[k].wr, vt[k].wexp);
    end

    // rdata holds across stores and errors.
    chk("i_rdata_hold", i_rdata, 32'h7700_0044);
    chk("d_rdata_hold", d_rdata, 32'hA500_00F9);
    run_txn(1'b0, 1'b0, 32'h3F0, 32'h0, 4'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0);
    chk("i_rdata_after_err", i_rdata, 32'h7700_0044);

    // Reset during RMW_RD aborts the partial store.
    @(posedge clk); #1;
    wbase = wr_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h114; d_wdata = 32'h1234_5678; d_be = 4'b0011;
    @(posedge clk); #1;
    chk("rmw_rd_entered", 32'(mem_read), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; d_req = 1'b0;
    chk("abort_strobes", {29'd0, mem_read, mem_write, d_done}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_write", 32'(wr_cnt - wbase), 32'd0);
    chk("abort_ram_intact", ram[69], 32'hA500_0045);
    chk("abort_d_rdata_cleared", d_rdata, 32'd0);
    run_txn(1'b1, 1'b0, 32'h114, 32'h0, 4'hF, 1'b0, 32'hA500_0045, 2, 1, 0, 32'h0);

    repeat (3) @(posedge clk);
    chk("sb_empty_at_end", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
